// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data_mem port: m0 (MEM stage) has priority,
// m1 (loader/debug) is forced through after STARVE_LIMIT consecutive m0 wins.
module dmem_arbiter #(
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [1:0]  i_m0_size,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [1:0]  i_m1_size,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_size,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CW = 2;
  localparam int unsigned SW = 4;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RD_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_q, owner_d;
  logic [31:0]   rdata0_q, rdata1_q;
  logic          gnt0_c, gnt1_c, rvalid_c;
  logic          starve_at_limit;
  logic          grant_c;
  logic          pay_we;
  logic [31:0]   pay_addr, pay_wdata;
  logic [1:0]    pay_size;

  assign starve_at_limit = (starve_q == SW'(STARVE_LIMIT));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      starve_q <= '0;
      owner_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      if (o_m0_rvalid) rdata0_q <= i_mem_rdata;
      if (o_m1_rvalid) rdata1_q <= i_mem_rdata;
    end
  end

  // Arbitration, starvation tracking and read-latency countdown
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    rvalid_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_m0_req && !(i_m1_req && starve_at_limit)) gnt0_c = 1'b1;
        else if (i_m1_req)                              gnt1_c = 1'b1;
        if (gnt0_c || gnt1_c) begin
          if (gnt0_c && i_m1_req) starve_d = starve_at_limit ? starve_q : starve_q + SW'(1);
          else                    starve_d = '0;
          if (!(gnt1_c ? i_m1_we : i_m0_we)) begin
            owner_d  = gnt1_c;
            rd_cnt_d = CW'(RD_LATENCY);
            state_d  = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        rd_cnt_d = rd_cnt_q - CW'(1);
        if (rd_cnt_q == CW'(1)) begin
          rvalid_c = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Granted master's payload drives memory in the grant cycle; everything reads 0 in reset
  assign pay_we    = gnt1_c ? i_m1_we    : i_m0_we;
  assign pay_addr  = gnt1_c ? i_m1_addr  : i_m0_addr;
  assign pay_wdata = gnt1_c ? i_m1_wdata : i_m0_wdata;
  assign pay_size  = gnt1_c ? i_m1_size  : i_m0_size;
  assign grant_c   = (gnt0_c | gnt1_c) & ~i_rst;

  assign o_m0_gnt    = gnt0_c & ~i_rst;
  assign o_m1_gnt    = gnt1_c & ~i_rst;
  assign o_mem_we    = grant_c & pay_we;
  assign o_mem_re    = grant_c & ~pay_we;
  assign o_mem_addr  = grant_c ? pay_addr  : '0;
  assign o_mem_wdata = grant_c ? pay_wdata : '0;
  assign o_mem_size  = grant_c ? pay_size  : '0;

  assign o_m0_rvalid = rvalid_c & ~owner_q & ~i_rst;
  assign o_m1_rvalid = rvalid_c &  owner_q & ~i_rst;
  assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : rdata0_q;
  assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// grant-schedule model with a shadow memory.
module tb_dmem_arbiter;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [1:0]  m0_size = '0, m1_size = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] smem [16] = '{default: '0};
  logic [31:0] shadow [16];

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we, a_mem_re;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_mem_size;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_mem_re;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_mem_size;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LATENCY(LAT_A), .STARVE_LIMIT(LIMIT)) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_size(m0_size),
    .o_m0_gnt(a_m0_gnt), .o_m0_rvalid(a_m0_rvalid), .o_m0_rdata(a_m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_size(m1_size),
    .o_m1_gnt(a_m1_gnt), .o_m1_rvalid(a_m1_rvalid), .o_m1_rdata(a_m1_rdata),
    .o_mem_we(a_mem_we), .o_mem_re(a_mem_re), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .o_mem_size(a_mem_size), .i_mem_rdata(mem_rdata));

  dmem_arbiter #(.RD_LATENCY(LAT_B), .STARVE_LIMIT(LIMIT)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_size(m0_size),
    .o_m0_gnt(b_m0_gnt), .o_m0_rvalid(b_m0_rvalid), .o_m0_rdata(b_m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_size(m1_size),
    .o_m1_gnt(b_m1_gnt), .o_m1_rvalid(b_m1_rvalid), .o_m1_rdata(b_m1_rdata),
    .o_mem_we(b_mem_we), .o_mem_re(b_mem_re), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .o_mem_size(b_mem_size), .i_mem_rdata(mem_rdata));

  // Word memory with one cycle of read latency, serving instance u_a
  always @(posedge clk) begin
    if (a_mem_we) smem[a_mem_addr[5:2]] <= a_mem_wdata;
    if (a_mem_re) mem_rdata <= smem[a_mem_addr[5:2]];
  end

  task automatic clear_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_size = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_size = '0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    total++;
    if ({a_m0_gnt, a_m0_rvalid, a_m0_rdata, a_m1_gnt, a_m1_rvalid, a_m1_rdata,
         a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata, a_mem_size} !== '0) begin
      bad++; $display("FAIL reset_idle got gnt=%b%b we=%b re=%b addr=%h exp all zero",
                      a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_re, a_mem_addr);
    end
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h24; m0_wdata = 32'h1234_5678; m0_size = 2'd2;
    @(negedge clk);
    total++;
    if ({a_m0_gnt, a_mem_we} !== 2'b11) begin
      bad++; $display("FAIL reset_pre_gnt got gnt=%b we=%b exp 1 1", a_m0_gnt, a_mem_we);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a_m0_gnt, a_m0_rvalid, a_m0_rdata, a_m1_gnt, a_m1_rvalid, a_m1_rdata,
         a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata, a_mem_size} !== '0) begin
      bad++; $display("FAIL reset_async got gnt=%b we=%b addr=%h wdata=%h exp all zero",
                      a_m0_gnt, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    total++;
    if ({a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_re, a_m0_rvalid, a_m1_rvalid} !== '0) begin
      bad++; $display("FAIL reset_release got %b exp 000000",
                      {a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_re, a_m0_rvalid, a_m1_rvalid});
    end
  endtask

  task automatic test_write_read();
    reset_dut();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; m0_size = 2'd2;
    @(negedge clk);
    total++;
    if ({a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata, a_mem_size} !==
        {4'b1010, 32'h10, 32'hDEAD_BEEF, 2'd2}) begin
      bad++; $display("FAIL wr_gnt got gnt=%b we=%b addr=%h wdata=%h size=%0d exp 1 1 10 deadbeef 2",
                      a_m0_gnt, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_size);
    end
    @(posedge clk); #1;
    m0_we = 1'b0; m0_wdata = '0;
    @(negedge clk);
    total++;
    if ({a_m0_gnt, a_mem_we, a_mem_re, a_mem_addr} !== {3'b101, 32'h10}) begin
      bad++; $display("FAIL rd_gnt got gnt=%b we=%b re=%b addr=%h exp 1 0 1 10",
                      a_m0_gnt, a_mem_we, a_mem_re, a_mem_addr);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({a_m0_rvalid, a_m0_rdata, a_m1_rvalid, a_m0_gnt} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
      bad++; $display("FAIL rd_rvalid got rvalid=%b rdata=%h exp 1 deadbeef", a_m0_rvalid, a_m0_rdata);
    end
    @(negedge clk);
    total++;
    if ({a_m0_rvalid, a_m0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL rd_hold got rvalid=%b rdata=%h exp 0 deadbeef", a_m0_rvalid, a_m0_rdata);
    end
  endtask

  task automatic test_starvation();
    int streak = 0;
    int busy = 0;
    int ng = 0;
    int n0 = 0;
    int n1 = 0;
    logic e0, e1;
    reset_dut();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
    for (int c = 0; c < 300 && ng < 50; c++) begin
      @(negedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (busy > 0) busy--;
      else begin
        if (streak == LIMIT) begin e1 = 1'b1; streak = 0; end
        else begin e0 = 1'b1; streak++; end
        busy = LAT_A;
        ng++;
      end
      if (a_m0_gnt === 1'b1) n0++;
      if (a_m1_gnt === 1'b1) n1++;
      total++;
      if ({a_m0_gnt, a_m1_gnt} !== {e0, e1}) begin
        bad++; $display("FAIL starve_gnt c=%0d got=%b%b exp=%b%b", c, a_m0_gnt, a_m1_gnt, e0, e1);
      end
    end
    total++;
    if (n0 != 40 || n1 != 10) begin
      bad++; $display("FAIL starve_counts got m0=%0d m1=%0d exp m0=40 m1=10", n0, n1);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int n0 = 0;
    int n1 = 0;
    logic e0;
    reset_dut();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = 32'hA0A0_0000; m0_size = 2'd2;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h34; m1_wdata = 32'hB1B1_0000; m1_size = 2'd2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e0 = ((c % (LIMIT + 1)) != LIMIT);
      if (a_m0_gnt === 1'b1) n0++;
      if (a_m1_gnt === 1'b1) n1++;
      total++;
      if ({a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_re} !== {e0, ~e0, 2'b10}) begin
        bad++; $display("FAIL b2b c=%0d got gnt=%b%b we=%b re=%b exp gnt=%b%b we=1 re=0",
                        c, a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_re, e0, ~e0);
      end
      @(posedge clk); #1;
      m0_wdata = m0_wdata + 32'd1;
      m1_wdata = m1_wdata + 32'd1;
    end
    total++;
    if (n0 != 16 || n1 != 4) begin
      bad++; $display("FAIL b2b_counts got m0=%0d m1=%0d exp m0=16 m1=4", n0, n1);
    end
    clear_inputs();
  endtask

  task automatic test_rd_wait_blip();
    logic e0;
    reset_dut();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk);
    total++;
    if (a_m0_gnt !== 1'b1) begin
      bad++; $display("FAIL blip_rd_gnt got=%b exp=1", a_m0_gnt);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h3C; m1_wdata = 32'h5555_AAAA; m1_size = 2'd2;
    @(negedge clk);
    total++;
    if ({a_m1_gnt, a_m0_gnt, a_mem_we, a_mem_re, a_mem_addr} !== '0) begin
      bad++; $display("FAIL blip_wait got gnt=%b%b we=%b re=%b addr=%h exp all zero",
                      a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_re, a_mem_addr);
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    total++;
    if ({a_m1_gnt, a_m0_gnt, a_mem_we, a_mem_re} !== 4'b0000) begin
      bad++; $display("FAIL blip_drop got %b exp 0000", {a_m1_gnt, a_m0_gnt, a_mem_we, a_mem_re});
    end
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_wdata = 32'h0F0F_0F0F;
    m1_req = 1'b1;
    for (int c = 0; c <= LIMIT; c++) begin
      @(negedge clk);
      e0 = (c != LIMIT);
      total++;
      if ({a_m0_gnt, a_m1_gnt} !== {e0, ~e0}) begin
        bad++; $display("FAIL blip_starve c=%0d got=%b%b exp=%b%b", c, a_m0_gnt, a_m1_gnt, e0, ~e0);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset_rd_wait();
    reset_dut();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_size = 2'd2;
    @(negedge clk);
    total++;
    if (b_m1_gnt !== 1'b1) begin
      bad++; $display("FAIL rstw_gnt got=%b exp=1", b_m1_gnt);
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({b_m1_rvalid, b_m1_gnt, b_m0_gnt, b_mem_we, b_mem_re, b_mem_addr} !== '0) begin
      bad++; $display("FAIL rstw_async got rvalid=%b gnt=%b%b exp 0", b_m1_rvalid, b_m0_gnt, b_m1_gnt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (b_m1_rvalid !== 1'b0) begin
        bad++; $display("FAIL rstw_held c=%0d rvalid got=%b exp=0", c, b_m1_rvalid);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h28; m0_wdata = 32'hCAFE_F00D; m0_size = 2'd2;
    @(negedge clk);
    total++;
    if ({b_m0_gnt, b_mem_we, b_m1_rvalid} !== 3'b110) begin
      bad++; $display("FAIL rstw_m0_gnt got gnt=%b we=%b rvalid1=%b exp 1 1 0", b_m0_gnt, b_mem_we, b_m1_rvalid);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (b_m1_rvalid !== 1'b0) begin
        bad++; $display("FAIL rstw_after c=%0d rvalid got=%b exp=0", c, b_m1_rvalid);
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int streak = 0;
    int busy_end = -1;
    int rv_cyc = -1;
    logic rv_own = 1'b0;
    logic [31:0] rv_data = '0, last0, last1, xaddr, xwdata;
    logic e0 = 1'b0, e1 = 1'b0, ev0, ev1, xwe, xre;
    logic [1:0] xsize;
    reset_dut();
    for (int i = 0; i < 16; i++) shadow[i] = smem[i];
    last0 = '0; last1 = '0;
    for (int c = 0; c < 600; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      if (m0_req && !e0 && $urandom_range(7) == 0) m0_req = 1'b0;
      else if (e0 || !m0_req) begin
        m0_req = 1'($urandom_range(1)); m0_we = 1'($urandom_range(1));
        m0_addr = {26'd0, 4'($urandom_range(15)), 2'b00}; m0_wdata = $urandom; m0_size = 2'd2;
      end
      if (m1_req && !e1 && $urandom_range(7) == 0) m1_req = 1'b0;
      else if (e1 || !m1_req) begin
        m1_req = 1'($urandom_range(1)); m1_we = 1'($urandom_range(1));
        m1_addr = {26'd0, 4'($urandom_range(15)), 2'b00}; m1_wdata = $urandom; m1_size = 2'($urandom_range(2));
      end
      @(negedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (c > busy_end) begin
        if (m0_req && m1_req) begin
          if (streak == LIMIT) e1 = 1'b1; else e0 = 1'b1;
        end else begin
          e0 = m0_req; e1 = m1_req;
        end
      end
      xwe    = (e0 & m0_we) | (e1 & m1_we);
      xre    = (e0 & ~m0_we) | (e1 & ~m1_we);
      xaddr  = e0 ? m0_addr  : (e1 ? m1_addr  : 32'h0);
      xwdata = e0 ? m0_wdata : (e1 ? m1_wdata : 32'h0);
      xsize  = e0 ? m0_size  : (e1 ? m1_size  : 2'd0);
      ev0 = (c == rv_cyc) && !rv_own;
      ev1 = (c == rv_cyc) && rv_own;
      if (ev0) last0 = rv_data;
      if (ev1) last1 = rv_data;
      total++;
      if ({a_m0_gnt, a_m1_gnt} !== {e0, e1}) begin
        bad++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, a_m0_gnt, a_m1_gnt, e0, e1);
      end
      total++;
      if ({a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata, a_mem_size} !== {xwe, xre, xaddr, xwdata, xsize}) begin
        bad++; $display("FAIL rnd_mem c=%0d got we=%b re=%b a=%h d=%h s=%0d exp we=%b re=%b a=%h d=%h s=%0d",
                        c, a_mem_we, a_mem_re, a_mem_addr, a_mem_wdata, a_mem_size, xwe, xre, xaddr, xwdata, xsize);
      end
      total++;
      if ({a_m0_rvalid, a_m0_rdata, a_m1_rvalid, a_m1_rdata} !== {ev0, last0, ev1, last1}) begin
        bad++; $display("FAIL rnd_rd c=%0d got v0=%b d0=%h v1=%b d1=%h exp v0=%b d0=%h v1=%b d1=%h",
                        c, a_m0_rvalid, a_m0_rdata, a_m1_rvalid, a_m1_rdata, ev0, last0, ev1, last1);
      end
      if (e0 || e1) begin
        streak = (e0 && m1_req) ? streak + 1 : 0;
        if (xwe) shadow[xaddr[5:2]] = xwdata;
        else begin
          rv_cyc   = c + LAT_A;
          rv_own   = e1;
          rv_data  = shadow[xaddr[5:2]];
          busy_end = c + LAT_A;
        end
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_starvation();
    test_back_to_back();
    test_rd_wait_blip();
    test_reset_rd_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
